// File: rtl/pc_redirect_ctrl_pkg.sv
// Shared definitions for the PC redirect controller: FSM states and the
// redirect-source encoding seen on o_redir_src.
package pc_redirect_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StRedirect = 2'd1,
    StFlush    = 2'd2
  } redir_state_e;

  localparam logic [1:0] SrcNone   = 2'b00;
  localparam logic [1:0] SrcBranch = 2'b01;
  localparam logic [1:0] SrcJump   = 2'b10;
  localparam logic [1:0] SrcTrap   = 2'b11;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/flush_counter.sv
// Saturating down-counter that times the wrong-path squash window after a
// redirect has been accepted by fetch.
module flush_counter #(
  parameter int unsigned FLUSH_DEPTH = 2,
  localparam int unsigned CntW = $clog2(FLUSH_DEPTH + 1)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_load,
  input  logic            i_clear,
  input  logic            i_dec,
  output logic [CntW-1:0] o_cnt,
  output logic            o_zero
);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      cnt_q <= '0;
    end else if (i_clear) begin
      cnt_q <= '0;
    end else if (i_load) begin
      cnt_q <= CntW'(FLUSH_DEPTH - 1);
    end else if (i_dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CntW'(1);
    end
  end

  assign o_cnt  = cnt_q;
  assign o_zero = (cnt_q == '0);

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Arbitrates trap/jump/branch PC updates into a single registered redirect
// offered to fetch, then squashes the wrong-path pipeline for FLUSH_DEPTH cycles.
module pc_redirect_ctrl
  import pc_redirect_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_jmp_req,
  input  logic [31:0] i_jmp_target,
  input  logic        i_br_req,
  input  logic [31:0] i_br_target,
  input  logic        i_trap_req,
  input  logic [31:0] i_trap_vec,
  input  logic        i_fetch_ready,
  output logic        o_redir_valid,
  output logic [31:0] o_redir_addr,
  output logic [1:0]  o_redir_src,
  output logic        o_flush,
  output logic        o_stall,
  output logic        o_misalign,
  output logic [31:0] o_bad_addr
);

  localparam int unsigned CntW = $clog2(FLUSH_DEPTH + 1);

  redir_state_e state_q, state_d;
  logic         valid_q, valid_d;
  logic [31:0]  addr_q, addr_d;
  logic [1:0]   src_q, src_d;
  logic         flush_q, flush_d;
  logic         stall_q, stall_d;
  logic         mis_q, mis_d;
  logic [31:0]  bad_q, bad_d;

  logic            cnt_load, cnt_clear, cnt_dec, cnt_zero;
  logic [CntW-1:0] cnt;

  flush_counter #(
    .FLUSH_DEPTH(FLUSH_DEPTH)
  ) u_flush_counter (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_load (cnt_load),
    .i_clear(cnt_clear),
    .i_dec  (cnt_dec),
    .o_cnt  (cnt),
    .o_zero (cnt_zero)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    src_d     = src_q;
    mis_d     = 1'b0;
    bad_d     = bad_q;
    cnt_load  = 1'b0;
    cnt_clear = 1'b0;
    cnt_dec   = 1'b0;

    case (state_q)
      StIdle: begin
        // Only the winner is considered; a misaligned winner blocks the losers too.
        if (i_trap_req) begin
          state_d = StRedirect;
          addr_d  = word_align(i_trap_vec);
          src_d   = SrcTrap;
        end else if (i_jmp_req) begin
          if (i_jmp_target[1:0] != 2'b00) begin
            mis_d = 1'b1;
            bad_d = i_jmp_target;
          end else begin
            state_d = StRedirect;
            addr_d  = i_jmp_target;
            src_d   = SrcJump;
          end
        end else if (i_br_req) begin
          if (i_br_target[1:0] != 2'b00) begin
            mis_d = 1'b1;
            bad_d = i_br_target;
          end else begin
            state_d = StRedirect;
            addr_d  = i_br_target;
            src_d   = SrcBranch;
          end
        end
      end
      StRedirect: begin
        // A trap on the accept cycle beats the handoff to FLUSH.
        if (i_trap_req) begin
          addr_d    = word_align(i_trap_vec);
          src_d     = SrcTrap;
          cnt_clear = 1'b1;
        end else if (i_fetch_ready) begin
          state_d  = StFlush;
          cnt_load = 1'b1;
        end
      end
      StFlush: begin
        if (i_trap_req) begin
          state_d   = StRedirect;
          addr_d    = word_align(i_trap_vec);
          src_d     = SrcTrap;
          cnt_clear = 1'b1;
        end else if (cnt_zero) begin
          state_d = StIdle;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    valid_d = (state_d == StRedirect);
    stall_d = (state_d == StRedirect);
    flush_d = (state_d != StIdle);
    if (state_d != StRedirect) begin
      src_d = SrcNone;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= StIdle;
      valid_q <= 1'b0;
      addr_q  <= '0;
      src_q   <= SrcNone;
      flush_q <= 1'b0;
      stall_q <= 1'b0;
      mis_q   <= 1'b0;
      bad_q   <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      addr_q  <= addr_d;
      src_q   <= src_d;
      flush_q <= flush_d;
      stall_q <= stall_d;
      mis_q   <= mis_d;
      bad_q   <= bad_d;
    end
  end

  assign o_redir_valid = valid_q;
  assign o_redir_addr  = addr_q;
  assign o_redir_src   = src_q;
  assign o_flush       = flush_q;
  assign o_stall       = stall_q;
  assign o_misalign    = mis_q;
  assign o_bad_addr    = bad_q;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed bench for pc_redirect_ctrl: a transaction-level model checked every
// cycle, plus hand-computed expectations for each scenario.
module tb_pc_redirect_ctrl;

  localparam int unsigned FLUSH_DEPTH = 2;

  logic        i_clk;
  logic        i_rst;
  logic        i_jmp_req, i_br_req, i_trap_req, i_fetch_ready;
  logic [31:0] i_jmp_target, i_br_target, i_trap_vec;
  logic        o_redir_valid, o_flush, o_stall, o_misalign;
  logic [31:0] o_redir_addr, o_bad_addr;
  logic [1:0]  o_redir_src;

  int n_cmp = 0;
  int n_bad = 0;

  pc_redirect_ctrl #(
    .FLUSH_DEPTH(FLUSH_DEPTH)
  ) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_jmp_req    (i_jmp_req),
    .i_jmp_target (i_jmp_target),
    .i_br_req     (i_br_req),
    .i_br_target  (i_br_target),
    .i_trap_req   (i_trap_req),
    .i_trap_vec   (i_trap_vec),
    .i_fetch_ready(i_fetch_ready),
    .o_redir_valid(o_redir_valid),
    .o_redir_addr (o_redir_addr),
    .o_redir_src  (o_redir_src),
    .o_flush      (o_flush),
    .o_stall      (o_stall),
    .o_misalign   (o_misalign),
    .o_bad_addr   (o_bad_addr)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got 0x%08h, required 0x%08h", name, $time, act, exp);
    end
  endfunction

  // Model: a redirect is either being offered, or some number of squash cycles remain.
  typedef struct packed {
    bit          offering;
    logic [31:0] addr;
    logic [1:0]  src;
    int          flush_left;
    bit          mis;
    logic [31:0] bad;
  } model_t;

  model_t m;

  function automatic model_t take(model_t c, logic [31:0] tgt, logic [1:0] src);
    model_t n = c;
    if (tgt % 4 != 0) begin
      n.mis = 1'b1;
      n.bad = tgt;
    end else begin
      n.offering = 1'b1;
      n.addr     = tgt;
      n.src      = src;
    end
    return n;
  endfunction

  function automatic model_t model_step(model_t c);
    model_t n = c;
    n.mis = 1'b0;
    if (c.offering) begin
      if (i_trap_req) begin
        n.addr = i_trap_vec & 32'hFFFF_FFFC;
        n.src  = 2'd3;
      end else if (i_fetch_ready) begin
        n.offering   = 1'b0;
        n.flush_left = FLUSH_DEPTH;
      end
    end else if (c.flush_left > 0) begin
      if (i_trap_req) begin
        n.offering   = 1'b1;
        n.addr       = i_trap_vec & 32'hFFFF_FFFC;
        n.src        = 2'd3;
        n.flush_left = 0;
      end else begin
        n.flush_left = c.flush_left - 1;
      end
    end else if (i_trap_req) begin
      n.offering = 1'b1;
      n.addr     = i_trap_vec & 32'hFFFF_FFFC;
      n.src      = 2'd3;
    end else if (i_jmp_req) begin
      n = take(n, i_jmp_target, 2'd2);
    end else if (i_br_req) begin
      n = take(n, i_br_target, 2'd1);
    end
    return n;
  endfunction

  always @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) m <= '0;
    else        m <= model_step(m);
  end

  always @(negedge i_clk) begin
    check("model_valid", {31'd0, o_redir_valid}, {31'd0, m.offering});
    check("model_addr", o_redir_addr, m.addr);
    check("model_src", {30'd0, o_redir_src}, m.offering ? {30'd0, m.src} : 32'd0);
    check("model_flush", {31'd0, o_flush}, {31'd0, m.offering || (m.flush_left > 0)});
    check("model_stall", {31'd0, o_stall}, {31'd0, m.offering});
    check("model_misalign", {31'd0, o_misalign}, {31'd0, m.mis});
    check("model_bad_addr", o_bad_addr, m.bad);
  end

  task automatic cyc;
    @(negedge i_clk);
  endtask

  task automatic expect_redirect(string name, logic [31:0] addr, logic [1:0] src);
    check({name, "_valid"}, {31'd0, o_redir_valid}, 32'd1);
    check({name, "_addr"}, o_redir_addr, addr);
    check({name, "_src"}, {30'd0, o_redir_src}, {30'd0, src});
    check({name, "_stall"}, {31'd0, o_stall}, 32'd1);
    check({name, "_flush"}, {31'd0, o_flush}, 32'd1);
  endtask

  initial begin
    i_rst = 1'b1;
    i_jmp_req = 1'b0; i_br_req = 1'b0; i_trap_req = 1'b0; i_fetch_ready = 1'b0;
    i_jmp_target = '0; i_br_target = '0; i_trap_vec = '0;
    #1 i_rst = 1'b0;
    repeat (2) cyc;
    check("rst_valid", {31'd0, o_redir_valid}, 32'd0);
    check("rst_flush", {31'd0, o_flush}, 32'd0);
    check("rst_bad", o_bad_addr, 32'd0);
    i_rst = 1'b1;

    // Jump with fetch ready: one valid cycle, FLUSH_DEPTH flush cycles, then idle.
    i_jmp_req = 1'b1; i_jmp_target = 32'h0000_0100; i_fetch_ready = 1'b1;
    cyc;
    i_jmp_req = 1'b0;
    expect_redirect("jmp", 32'h100, 2'b10);
    cyc;
    check("jmp_c2_valid", {31'd0, o_redir_valid}, 32'd0);
    check("jmp_c2_flush", {31'd0, o_flush}, 32'd1);
    check("jmp_c2_stall", {31'd0, o_stall}, 32'd0);
    check("jmp_c2_src", {30'd0, o_redir_src}, 32'd0);
    cyc;
    check("jmp_c3_flush", {31'd0, o_flush}, 32'd1);
    cyc;
    check("jmp_c4_flush", {31'd0, o_flush}, 32'd0);

    // All three at once: trap wins and its vector is word-aligned.
    i_trap_req = 1'b1; i_trap_vec = 32'h0000_0203;
    i_jmp_req = 1'b1; i_jmp_target = 32'h0000_0011;
    i_br_req = 1'b1; i_br_target = 32'h0000_0044; i_fetch_ready = 1'b0;
    cyc;
    i_trap_req = 1'b0; i_jmp_req = 1'b0; i_br_req = 1'b0;
    expect_redirect("prio", 32'h200, 2'b11);
    check("prio_misalign", {31'd0, o_misalign}, 32'd0);
    i_fetch_ready = 1'b1;
    repeat (FLUSH_DEPTH + 1) cyc;
    check("prio_idle", {31'd0, o_flush}, 32'd0);

    // Misaligned branch: one-cycle pulse, no redirect.
    i_br_req = 1'b1; i_br_target = 32'h0000_0102;
    cyc;
    i_br_req = 1'b0;
    check("mis_pulse", {31'd0, o_misalign}, 32'd1);
    check("mis_bad", o_bad_addr, 32'h102);
    check("mis_valid", {31'd0, o_redir_valid}, 32'd0);
    check("mis_flush", {31'd0, o_flush}, 32'd0);
    cyc;
    check("mis_drop", {31'd0, o_misalign}, 32'd0);
    check("mis_hold", o_bad_addr, 32'h102);

    // Backpressure: fetch not ready for 3 cycles, wrong-path branch held meanwhile.
    i_jmp_req = 1'b1; i_jmp_target = 32'h0000_0400; i_fetch_ready = 1'b0;
    cyc;
    i_jmp_req = 1'b0; i_br_req = 1'b1; i_br_target = 32'h0000_0800;
    for (int i = 0; i < 4; i++) begin
      expect_redirect("hold", 32'h400, 2'b10);
      if (i == 3) i_fetch_ready = 1'b1;
      cyc;
    end
    check("hold_accept_valid", {31'd0, o_redir_valid}, 32'd0);
    check("hold_accept_flush", {31'd0, o_flush}, 32'd1);
    i_br_req = 1'b0;
    repeat (FLUSH_DEPTH) cyc;
    check("hold_idle_flush", {31'd0, o_flush}, 32'd0);
    check("hold_idle_addr", o_redir_addr, 32'h400);

    // Trap in the first FLUSH cycle re-enters REDIRECT and restarts the full flush.
    i_jmp_req = 1'b1; i_jmp_target = 32'h0000_0100; i_fetch_ready = 1'b1;
    cyc;
    i_jmp_req = 1'b0;
    cyc;
    check("ftrap_in_flush", {31'd0, o_flush}, 32'd1);
    i_trap_req = 1'b1; i_trap_vec = 32'h0000_0303; i_fetch_ready = 1'b0;
    cyc;
    i_trap_req = 1'b0;
    expect_redirect("ftrap", 32'h300, 2'b11);
    i_fetch_ready = 1'b1;
    cyc;
    for (int i = 0; i < FLUSH_DEPTH; i++) begin
      check("ftrap_flush", {31'd0, o_flush}, 32'd1);
      cyc;
    end
    check("ftrap_idle", {31'd0, o_flush}, 32'd0);

    // Trap on the accept cycle keeps REDIRECT with the trap vector.
    i_jmp_req = 1'b1; i_jmp_target = 32'h0000_0104;
    cyc;
    i_jmp_req = 1'b0; i_trap_req = 1'b1; i_trap_vec = 32'h0000_0501;
    cyc;
    i_trap_req = 1'b0;
    expect_redirect("atrap", 32'h500, 2'b11);
    cyc;
    check("atrap_accept", {31'd0, o_redir_valid}, 32'd0);
    repeat (FLUSH_DEPTH) cyc;
    check("atrap_idle", {31'd0, o_flush}, 32'd0);

    // Asynchronous reset mid-REDIRECT, held jump serviced after release.
    i_jmp_req = 1'b1; i_jmp_target = 32'h0000_0600; i_fetch_ready = 1'b0;
    cyc;
    expect_redirect("prerst", 32'h600, 2'b10);
    #2 i_rst = 1'b0;
    i_jmp_target = 32'h0000_0700;
    #1;
    check("arst_valid", {31'd0, o_redir_valid}, 32'd0);
    check("arst_addr", o_redir_addr, 32'd0);
    check("arst_src", {30'd0, o_redir_src}, 32'd0);
    check("arst_flush", {31'd0, o_flush}, 32'd0);
    check("arst_stall", {31'd0, o_stall}, 32'd0);
    cyc;
    i_rst = 1'b1;
    cyc;
    i_jmp_req = 1'b0;
    expect_redirect("postrst", 32'h700, 2'b10);
    i_fetch_ready = 1'b1;
    repeat (FLUSH_DEPTH + 1) cyc;
    check("final_idle", {31'd0, o_flush}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
